// File: rtl/any1_memreq_seq.sv
// Memory request sequencer: aligns byte selects and store data to a 32-byte bus, splits
// boundary-crossing accesses into two bus cycles and realigns load data.
// Optional bus timeout is compiled in with `define ANY1_MEMREQ_TIMEOUT_EN.
module any1_memreq_seq #(
  parameter int unsigned AWID      = 32,
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  output logic            req_rdy_o,
  input  logic            req_we_i,
  input  logic [AWID-1:0] req_adr_i,
  input  logic [31:0]     req_sel_i,
  input  logic [255:0]    req_dat_i,
  output logic            resp_v_o,
  output logic            resp_err_o,
  output logic [255:0]    resp_dat_o,
  output logic            cyc_o,
  output logic            stb_o,
  output logic            we_o,
  output logic [31:0]     sel_o,
  output logic [AWID-1:0] adr_o,
  output logic [255:0]    dat_o,
  input  logic            ack_i,
  input  logic            err_i,
  input  logic [255:0]    dat_i
);

  localparam logic [AWID-1:0] BlkBytes = AWID'(32);

  typedef enum logic [1:0] {StIdle, StAcc1, StAcc2, StDone} state_e;

  state_e          r_state;
  logic [63:0]     r_sel;
  logic [511:0]    r_dat;
  logic [AWID-1:0] r_base;
  logic            r_we;
  logic [4:0]      r_off;
  logic [511:0]    r_rbuf;

  logic            r_req_rdy;
  logic            r_resp_v;
  logic            r_resp_err;
  logic [255:0]    r_resp_dat;
  logic            r_cyc;
  logic            r_stb;
  logic            r_bwe;
  logic [31:0]     r_bsel;
  logic [AWID-1:0] r_badr;
  logic [255:0]    r_bdat;

  logic [63:0]     w_sel64;
  logic [511:0]    w_dat512;
  logic [AWID-1:0] w_base;
  logic            w_active;
  logic            w_to;
  logic            w_err;
  logic            w_ack;
  logic            w_finish;
  logic [511:0]    w_rbuf_nx;
  logic [255:0]    w_resp_sh;
  logic [255:0]    w_resp;

  function automatic logic [255:0] lane_mask(input logic [31:0] sel);
    logic [255:0] m;
    for (int i = 0; i < 32; i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

  assign w_sel64  = {32'b0, req_sel_i} << req_adr_i[4:0];
  assign w_dat512 = {256'b0, req_dat_i} << {req_adr_i[4:0], 3'b000};
  assign w_base   = {req_adr_i[AWID-1:5], 5'b0};

  // r_stb is low during the bubble, so ack/err are ignored there as well as outside ACC1/ACC2.
  assign w_active = r_stb && ((r_state == StAcc1) || (r_state == StAcc2));
  assign w_err    = w_active && (err_i || w_to);
  assign w_ack    = w_active && ack_i && !w_err;
  assign w_finish = w_err || (w_ack && ((r_state == StAcc2) || (r_sel[63:32] == '0)));

  always_comb begin
    w_rbuf_nx = r_rbuf;
    if (r_state == StAcc1) begin
      w_rbuf_nx[255:0] = dat_i & lane_mask(r_sel[31:0]);
    end else begin
      w_rbuf_nx[511:256] = dat_i & lane_mask(r_sel[63:32]);
    end
  end

  assign w_resp_sh = 256'(w_rbuf_nx >> {r_off, 3'b000});
  assign w_resp    = r_we ? '0 : w_resp_sh;

`ifdef ANY1_MEMREQ_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        w_in_acc;

  assign w_in_acc = (r_state == StAcc1) || (r_state == StAcc2);
  assign w_to     = r_stb && (r_to_cnt >= TO_CYCLES);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_to_cnt <= '0;
    end else if (!w_in_acc || w_ack || w_err) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 32'd1;
    end
  end
`else
  logic w_unused_to;
  assign w_unused_to = ^TO_CYCLES;
  assign w_to        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StIdle;
      r_sel      <= '0;
      r_dat      <= '0;
      r_base     <= '0;
      r_we       <= 1'b0;
      r_off      <= '0;
      r_rbuf     <= '0;
      r_req_rdy  <= 1'b1;
      r_resp_v   <= 1'b0;
      r_resp_err <= 1'b0;
      r_resp_dat <= '0;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_bwe      <= 1'b0;
      r_bsel     <= '0;
      r_badr     <= '0;
      r_bdat     <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (req_i) begin
            r_sel     <= w_sel64;
            r_dat     <= w_dat512;
            r_base    <= w_base;
            r_we      <= req_we_i;
            r_off     <= req_adr_i[4:0];
            r_rbuf    <= '0;
            r_req_rdy <= 1'b0;
            if (w_sel64 == '0) begin
              r_state    <= StDone;
              r_resp_v   <= 1'b1;
              r_resp_err <= 1'b0;
              r_resp_dat <= '0;
            end else begin
              r_cyc <= 1'b1;
              r_stb <= 1'b1;
              r_bwe <= req_we_i;
              if (w_sel64[31:0] == '0) begin
                r_state <= StAcc2;
                r_badr  <= w_base + BlkBytes;
                r_bsel  <= w_sel64[63:32];
                r_bdat  <= w_dat512[511:256];
              end else begin
                r_state <= StAcc1;
                r_badr  <= w_base;
                r_bsel  <= w_sel64[31:0];
                r_bdat  <= w_dat512[255:0];
              end
            end
          end
        end
        StAcc1: begin
          if (w_ack && (r_sel[63:32] != '0)) begin
            // Second half follows after a one-cycle strobe bubble with cyc_o held.
            r_state <= StAcc2;
            r_stb   <= 1'b0;
            r_badr  <= r_base + BlkBytes;
            r_bsel  <= r_sel[63:32];
            r_bdat  <= r_dat[511:256];
          end
        end
        StAcc2: begin
          if (!r_stb) begin
            r_stb <= 1'b1;
          end
        end
        StDone: begin
          r_state   <= StIdle;
          r_resp_v  <= 1'b0;
          r_req_rdy <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase

      if (w_ack) begin
        r_rbuf <= w_rbuf_nx;
      end

      if (w_finish) begin
        r_state    <= StDone;
        r_cyc      <= 1'b0;
        r_stb      <= 1'b0;
        r_bwe      <= 1'b0;
        r_bsel     <= '0;
        r_badr     <= '0;
        r_bdat     <= '0;
        r_resp_v   <= 1'b1;
        r_resp_err <= w_err;
        r_resp_dat <= w_err ? '0 : w_resp;
      end
    end
  end

  assign req_rdy_o  = r_req_rdy;
  assign resp_v_o   = r_resp_v;
  assign resp_err_o = r_resp_err;
  assign resp_dat_o = r_resp_dat;
  assign cyc_o      = r_cyc;
  assign stb_o      = r_stb;
  assign we_o       = r_bwe;
  assign sel_o      = r_bsel;
  assign adr_o      = r_badr;
  assign dat_o      = r_bdat;

endmodule

// File: tb/tb_any1_memreq_seq.sv
// Bench for any1_memreq_seq: byte-level request model plus bus responder, checked every cycle,
// with directed literal checks for latency and alignment corner cases.
module tb_any1_memreq_seq;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         req_i = 1'b0;
  logic         req_rdy_o;
  logic         req_we_i = 1'b0;
  logic [31:0]  req_adr_i = '0;
  logic [31:0]  req_sel_i = '0;
  logic [255:0] req_dat_i = '0;
  logic         resp_v_o;
  logic         resp_err_o;
  logic [255:0] resp_dat_o;
  logic         cyc_o;
  logic         stb_o;
  logic         we_o;
  logic [31:0]  sel_o;
  logic [31:0]  adr_o;
  logic [255:0] dat_o;
  logic         ack_i = 1'b0;
  logic         err_i = 1'b0;
  logic [255:0] dat_i = '0;

  always #5 clk = ~clk;

  any1_memreq_seq #(
    .AWID      (32),
    .TO_CYCLES (4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .req_rdy_o  (req_rdy_o),
    .req_we_i   (req_we_i),
    .req_adr_i  (req_adr_i),
    .req_sel_i  (req_sel_i),
    .req_dat_i  (req_dat_i),
    .resp_v_o   (resp_v_o),
    .resp_err_o (resp_err_o),
    .resp_dat_o (resp_dat_o),
    .cyc_o      (cyc_o),
    .stb_o      (stb_o),
    .we_o       (we_o),
    .sel_o      (sel_o),
    .adr_o      (adr_o),
    .dat_o      (dat_o),
    .ack_i      (ack_i),
    .err_i      (err_i),
    .dat_i      (dat_i)
  );

  typedef struct packed {
    logic [31:0]  adr;
    logic [31:0]  sel;
    logic [255:0] dat;
    logic         we;
  } beat_t;

  typedef struct packed {
    logic         err;
    logic [255:0] dat;
  } resp_t;

  beat_t exp_beats[$];
  resp_t exp_resp[$];

  int n_checks = 0;
  int n_err = 0;

  // Responder configuration
  int ack_delay = 0;
  int err_beat = -1;
  int wait_cnt = 0;
  int beat_idx = 0;
  bit hang = 1'b0;
  bit force_err = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory contents seen on the bus: byte at address a is a[7:0]; unselected lanes read 0.
  function automatic logic [255:0] bus_data(input logic [31:0] adr, input logic [31:0] sel);
    logic [255:0] d;
    logic [31:0]  a;
    d = '0;
    for (int j = 0; j < 32; j++) begin
      a = adr + 32'(j);
      if (sel[j]) d[8*j +: 8] = a[7:0];
    end
    return d;
  endfunction

  function automatic void model_push(input logic [31:0] adr, input logic [31:0] sel,
                                     input logic [255:0] dat, input logic we, input logic err);
    logic [63:0]  s64;
    logic [511:0] d64;
    logic [31:0]  base;
    logic [31:0]  a;
    int           o;
    beat_t        b;
    resp_t        r;
    o    = int'(adr[4:0]);
    s64  = '0;
    d64  = '0;
    base = {adr[31:5], 5'b0};
    for (int i = 0; i < 32; i++) begin
      s64[o+i]           = sel[i];
      d64[8*(o+i) +: 8] = dat[8*i +: 8];
    end
    if (s64[31:0] != '0) begin
      b = '{adr: base, sel: s64[31:0], dat: d64[255:0], we: we};
      exp_beats.push_back(b);
    end
    if (s64[63:32] != '0) begin
      b = '{adr: base + 32'd32, sel: s64[63:32], dat: d64[511:256], we: we};
      exp_beats.push_back(b);
    end
    r.err = err;
    r.dat = '0;
    if (!err && !we) begin
      for (int i = 0; i < 32; i++) begin
        a = adr + 32'(i);
        if (sel[i]) r.dat[8*i +: 8] = a[7:0];
      end
    end
    exp_resp.push_back(r);
  endfunction

  // Bus responder and per-cycle compare against the model.
  beat_t cmp_b;
  resp_t cmp_r;
  always @(negedge clk) begin
    ack_i = 1'b0;
    err_i = 1'b0;
    dat_i = '0;
    if (rst_ni) begin
      if (cyc_o && stb_o) begin
        if (exp_beats.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_beat: got adr %0h sel %0h, required no bus strobe",
                   adr_o, sel_o);
        end else begin
          cmp_b = exp_beats[0];
          chk("bus_adr", {224'b0, adr_o}, {224'b0, cmp_b.adr});
          chk("bus_sel", {224'b0, sel_o}, {224'b0, cmp_b.sel});
          chk("bus_dat", dat_o, cmp_b.dat);
          chk("bus_we", {255'b0, we_o}, {255'b0, cmp_b.we});
          if (force_err) begin
            err_i     = 1'b1;
            force_err = 1'b0;
            exp_beats.delete();
          end else if (!hang) begin
            if (wait_cnt == ack_delay) begin
              wait_cnt = 0;
              if (beat_idx == err_beat) begin
                err_i = 1'b1;
                exp_beats.delete();
              end else begin
                ack_i = 1'b1;
                dat_i = bus_data(adr_o, sel_o);
                void'(exp_beats.pop_front());
                beat_idx++;
              end
            end else begin
              wait_cnt++;
            end
          end
        end
      end
      if (resp_v_o) begin
        if (exp_resp.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_resp: got resp_v_o=1, required 0");
        end else begin
          cmp_r = exp_resp.pop_front();
          chk("resp_err", {255'b0, resp_err_o}, {255'b0, cmp_r.err});
          chk("resp_dat", resp_dat_o, cmp_r.dat);
          exp_beats.delete();
        end
      end
    end
  end

  task automatic start_req(input logic [31:0] adr, input logic [31:0] sel,
                           input logic [255:0] dat, input logic we, input logic err,
                           output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!req_rdy_o && waited < 100);
    chk("req_rdy_wait", {255'b0, req_rdy_o}, 256'd1);
    wait_cnt = 0;
    beat_idx = 0;
    model_push(adr, sel, dat, we, err);
    req_i     = 1'b1;
    req_we_i  = we;
    req_adr_i = adr;
    req_sel_i = sel;
    req_dat_i = dat;
    @(posedge clk);
    #1;
    req_i     = 1'b0;
    req_we_i  = 1'b0;
    req_sel_i = '0;
    req_dat_i = '0;
  endtask

  // k counts sampling points after the accept edge; returns with resp_v_o seen at k.
  task automatic wait_resp(inout int k);
    while (k < 2000) begin
      @(negedge clk);
      k++;
      if (resp_v_o) break;
    end
    if (!resp_v_o) chk("resp_bound", {255'b0, resp_v_o}, 256'd1);
  endtask

  task automatic run_model(input logic [31:0] adr, input logic [31:0] sel,
                           input logic [255:0] dat, input logic we, input int dly);
    int w;
    int k;
    ack_delay = dly;
    err_beat  = -1;
    start_req(adr, sel, dat, we, 1'b0, w);
    k = 0;
    wait_resp(k);
  endtask

  initial begin
    int w;
    int k;
    int nresp;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdy", {255'b0, req_rdy_o}, 256'd1);
    chk("rst_cyc", {254'b0, cyc_o, stb_o}, 256'd0);
    chk("rst_we", {255'b0, we_o}, 256'd0);
    chk("rst_sel", {224'b0, sel_o}, 256'd0);
    chk("rst_adr", {224'b0, adr_o}, 256'd0);
    chk("rst_dat", dat_o, 256'd0);
    chk("rst_resp", {254'b0, resp_v_o, resp_err_o}, 256'd0);
    chk("rst_resp_dat", resp_dat_o, 256'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Aligned load, ack after two wait cycles
    ack_delay = 2;
    err_beat  = -1;
    start_req(32'h1000, 32'h0000FFFF, '0, 1'b0, 1'b0, w);
    @(negedge clk);
    k = 1;
    chk("al_cyc_stb", {254'b0, cyc_o, stb_o}, 256'd3);
    chk("al_adr", {224'b0, adr_o}, 256'h1000);
    chk("al_sel", {224'b0, sel_o}, 256'h0000FFFF);
    wait_resp(k);
    chk("al_lat", 256'(k), 256'd4);
    chk("al_dat", resp_dat_o, {128'h0, 128'h0F0E0D0C0B0A09080706050403020100});
    chk("al_err", {255'b0, resp_err_o}, 256'd0);

    // Crossing store
    ack_delay = 0;
    start_req(32'h101C, 32'h000000FF, 256'h8877665544332211, 1'b1, 1'b0, w);
    @(negedge clk);
    chk("xs_c1_cyc_stb", {254'b0, cyc_o, stb_o}, 256'd3);
    chk("xs_c1_adr", {224'b0, adr_o}, 256'h1000);
    chk("xs_c1_sel", {224'b0, sel_o}, 256'hF0000000);
    chk("xs_c1_dat", {224'b0, dat_o[255:224]}, 256'h44332211);
    @(negedge clk);
    chk("xs_bubble", {254'b0, cyc_o, stb_o}, 256'd2);
    @(negedge clk);
    chk("xs_c2_cyc_stb", {254'b0, cyc_o, stb_o}, 256'd3);
    chk("xs_c2_adr", {224'b0, adr_o}, 256'h1020);
    chk("xs_c2_sel", {224'b0, sel_o}, 256'h0000000F);
    chk("xs_c2_dat", {224'b0, dat_o[31:0]}, 256'h88776655);
    @(negedge clk);
    chk("xs_resp", {254'b0, resp_v_o, resp_err_o}, 256'd2);
    chk("xs_resp_dat", resp_dat_o, 256'd0);

    // Zero select: straight to DONE, no bus cycle
    start_req(32'h1100, 32'h0, 256'hDEAD, 1'b0, 1'b0, w);
    @(negedge clk);
    chk("zs_resp", {254'b0, resp_v_o, resp_err_o}, 256'd2);
    chk("zs_cyc", {255'b0, cyc_o}, 256'd0);

    // Error on second half of a crossing load
    ack_delay = 0;
    err_beat  = 1;
    start_req(32'h103E, 32'h0000000F, '0, 1'b0, 1'b1, w);
    k = 0;
    wait_resp(k);
    chk("er_lat", 256'(k), 256'd4);
    chk("er_err", {255'b0, resp_err_o}, 256'd1);
    chk("er_dat", resp_dat_o, 256'd0);
    @(negedge clk);
    chk("er_rdy", {255'b0, req_rdy_o}, 256'd1);
    chk("er_hold", {255'b0, resp_err_o}, 256'd1);
    err_beat = -1;

    // Model-checked loads and stores, including address wrap
    run_model(32'h2019, 32'h00FFFF0F, '0, 1'b0, 1);
    run_model(32'h3005, 32'hFFFFFFFF, '0, 1'b0, 0);
    run_model(32'h40E0, 32'h80000001, '0, 1'b0, 2);
    run_model(32'hFFFFFFF0, 32'hFFFFFFFF, '0, 1'b0, 0);
    run_model(32'h5010, 32'h0000FFFF, {8{32'hA5A55A5A}}, 1'b1, 1);
    run_model(32'h5033, 32'h00000001, 256'h77, 1'b1, 0);
    run_model(32'h6021, 32'h000000F0, '0, 1'b0, 0);

    // Minimum turnaround: single access, immediate ack
    ack_delay = 0;
    start_req(32'h8004, 32'h00000F0F, '0, 1'b0, 1'b0, w);
    k = 0;
    wait_resp(k);
    chk("ta_lat1", 256'(k), 256'd2);
    start_req(32'h8040, 32'h000000FF, '0, 1'b0, 1'b0, w);
    chk("ta_gap", 256'(w), 256'd1);
    k = 0;
    wait_resp(k);
    chk("ta_lat2", 256'(k), 256'd2);

    // Reset in the middle of ACC1
    hang = 1'b1;
    start_req(32'h9000, 32'h0000000F, '0, 1'b0, 1'b0, w);
    @(negedge clk);
    chk("mr_cyc_before", {255'b0, cyc_o}, 256'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mr_cyc_stb", {254'b0, cyc_o, stb_o}, 256'd0);
    chk("mr_rdy", {255'b0, req_rdy_o}, 256'd1);
    exp_beats.delete();
    exp_resp.delete();
    hang = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    nresp = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_v_o) nresp++;
    end
    chk("mr_no_resp", 256'(nresp), 256'd0);
    chk("mr_rdy_after", {255'b0, req_rdy_o}, 256'd1);

`ifdef ANY1_MEMREQ_TIMEOUT_EN
    // Timeout after TO_CYCLES=4 strobed cycles without ack
    hang = 1'b1;
    start_req(32'hA000, 32'h000000FF, '0, 1'b0, 1'b1, w);
    k = 0;
    wait_resp(k);
    chk("to_lat", 256'(k), 256'd6);
    chk("to_err", {255'b0, resp_err_o}, 256'd1);
    hang = 1'b0;
`else
    // No timeout: still waiting after 1000 cycles, then released by an error
    hang = 1'b1;
    start_req(32'hA000, 32'h000000FF, '0, 1'b0, 1'b1, w);
    nresp = 0;
    repeat (1000) begin
      @(negedge clk);
      if (resp_v_o) nresp++;
    end
    chk("nt_no_resp", 256'(nresp), 256'd0);
    chk("nt_waiting", {254'b0, cyc_o, stb_o}, 256'd3);
    force_err = 1'b1;
    hang      = 1'b0;
    k = 0;
    wait_resp(k);
    chk("nt_err", {255'b0, resp_err_o}, 256'd1);
`endif

    repeat (3) @(negedge clk);
    chk("left_beats", 256'(exp_beats.size()), 256'd0);
    chk("left_resp", 256'(exp_resp.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
